// File: rtl/rtl_settings_pkg.sv
// Shared settings for the traffic-generator control path: widths, CSR indices,
// test/address mode encodings and the LFSR step used for random addressing.
package rtl_settings_pkg;

  typedef enum logic {BYTE_ADDR, WORD_ADDR} addr_type_t;

  localparam int         ADDR_W      = 28;
  localparam int         AMM_BURST_W = 11;
  localparam int         ADDR_B_W    = 2;
  localparam addr_type_t ADDR_TYPE   = WORD_ADDR;

  localparam int CSR_TEST_PARAM = 1;
  localparam int CSR_SET_ADDR   = 2;
  localparam int CSR_SET_DATA   = 3;

  typedef enum logic [1:0] {
    WRITE_ONLY      = 2'd0,
    READ_ONLY       = 2'd1,
    WRITE_AND_CHECK = 2'd2
  } test_mode_t;

  typedef enum logic [1:0] {
    FIX_ADDR = 2'd0,
    INC_ADDR = 2'd1,
    RND_ADDR = 2'd2
  } addr_mode_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ISSUE_WR,
    ST_ISSUE_RD,
    ST_DRAIN,
    ST_DONE
  } ctrl_state_t;

  // Right-shift Galois form of x^32 + x^22 + x^2 + x + 1.
  localparam logic [31:0] LFSR_TAPS = 32'h8020_0003;

  function automatic logic [31:0] lfsr_next(input logic [31:0] cur);
    lfsr_next = cur[0] ? ((cur >> 1) ^ LFSR_TAPS) : (cur >> 1);
  endfunction

endpackage

// File: rtl/control_block_addr_gen.sv
// Address generator: fixed, incrementing or LFSR-random addresses, loaded at
// test start and advanced once per completed address.
module addr_gen
  import rtl_settings_pkg::*;
(
  input  logic                   rst_i,
  input  logic                   clk_i,
  input  logic                   load_i,
  input  logic                   adv_i,
  input  addr_mode_t             mode_i,
  input  logic [ADDR_W-1:0]      base_i,
  input  logic [AMM_BURST_W-2:0] burst_i,
  output logic [ADDR_W-1:0]      addr_o
);

  localparam int STEP_SHIFT = (ADDR_TYPE == BYTE_ADDR) ? ADDR_B_W : 0;

  addr_mode_t        mode_q, mode_d;
  logic [ADDR_W-1:0] step_q, step_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       lfsr_q, lfsr_d;
  logic [31:0]       seed;

  always_comb begin
    mode_d = mode_q;
    step_d = step_q;
    addr_d = addr_q;
    lfsr_d = lfsr_q;
    seed   = {{(32-ADDR_W){1'b0}}, base_i};
    if (seed == 32'd0) seed = 32'd1;

    if (load_i) begin
      mode_d = mode_i;
      step_d = ADDR_W'({1'b0, burst_i} + AMM_BURST_W'(1)) << STEP_SHIFT;
      if (mode_i == RND_ADDR) begin
        // The first random address is the state one step past the seed.
        lfsr_d = lfsr_next(seed);
        addr_d = lfsr_d[ADDR_W-1:0];
      end else begin
        addr_d = base_i;
      end
    end else if (adv_i) begin
      case (mode_q)
        INC_ADDR: addr_d = addr_q + step_q;
        RND_ADDR: begin
          lfsr_d = lfsr_next(lfsr_q);
          addr_d = lfsr_d[ADDR_W-1:0];
        end
        default:  addr_d = addr_q;
      endcase
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      mode_q <= FIX_ADDR;
      step_q <= '0;
      addr_q <= '0;
      lfsr_q <= 32'd1;
    end else begin
      mode_q <= mode_d;
      step_q <= step_d;
      addr_q <= addr_d;
      lfsr_q <= lfsr_d;
    end
  end

  assign addr_o = addr_q;

endmodule

// File: rtl/control_block.sv
// Test sequencer: issues write/read requests over a valid/ready handshake,
// counts accepts, aborts on compare error and waits for the transmitter to drain.
module control_block
  import rtl_settings_pkg::*;
(
  input  logic                                        rst_i,
  input  logic                                        clk_i,
  input  logic [CSR_SET_DATA:CSR_TEST_PARAM][31:0]    test_param_i,
  input  logic                                        start_i,
  input  logic                                        trans_ready_i,
  input  logic                                        trans_busy_i,
  input  logic                                        cmp_error_i,
  output logic                                        trans_valid_o,
  output logic [ADDR_W-1:0]                           trans_addr_o,
  output logic                                        trans_type_o,
  output logic                                        test_busy_o,
  output logic                                        test_done_o,
  output logic                                        test_error_o,
  output logic [31:0]                                 trans_cnt_o
);

  ctrl_state_t state_q, state_d;
  test_mode_t  mode_q, mode_d;
  logic [15:0] count_q, count_d;
  logic [15:0] done_q, done_d;
  logic [15:0] done_inc;
  logic        error_q, error_d;
  logic [31:0] tcnt_q, tcnt_d;
  logic        accept;
  logic        gen_load;
  logic        gen_adv;

  addr_gen u_addr_gen (
    .rst_i   (rst_i),
    .clk_i   (clk_i),
    .load_i  (gen_load),
    .adv_i   (gen_adv),
    .mode_i  (addr_mode_t'(test_param_i[CSR_TEST_PARAM][21:20])),
    .base_i  (test_param_i[CSR_SET_ADDR][ADDR_W-1:0]),
    .burst_i (test_param_i[CSR_TEST_PARAM][AMM_BURST_W-2:0]),
    .addr_o  (trans_addr_o)
  );

  assign accept   = trans_valid_o & trans_ready_i;
  assign done_inc = done_q + 16'd1;

  always_comb begin
    state_d       = state_q;
    mode_d        = mode_q;
    count_d       = count_q;
    done_d        = done_q;
    error_d       = error_q;
    tcnt_d        = tcnt_q;
    gen_load      = 1'b0;
    gen_adv       = 1'b0;
    trans_valid_o = (state_q == ST_ISSUE_WR) || (state_q == ST_ISSUE_RD);
    trans_type_o  = (state_q == ST_ISSUE_RD);
    test_busy_o   = (state_q != ST_IDLE);
    test_done_o   = (state_q == ST_DONE);

    if (accept && (tcnt_q != 32'hFFFF_FFFF)) tcnt_d = tcnt_q + 32'd1;

    case (state_q)
      ST_IDLE: begin
        if (start_i) begin
          mode_d   = test_mode_t'(test_param_i[CSR_TEST_PARAM][17:16]);
          count_d  = test_param_i[CSR_SET_DATA][31:16];
          done_d   = '0;
          error_d  = 1'b0;
          tcnt_d   = '0;
          gen_load = 1'b1;
          if (count_d == 16'd0)        state_d = ST_DRAIN;
          else if (mode_d == READ_ONLY) state_d = ST_ISSUE_RD;
          else                         state_d = ST_ISSUE_WR;
        end
      end
      ST_ISSUE_WR: begin
        if (accept) begin
          if (mode_q == WRITE_AND_CHECK) begin
            state_d = ST_ISSUE_RD;
          end else begin
            gen_adv = 1'b1;
            done_d  = done_inc;
            if (done_inc == count_q) state_d = ST_DRAIN;
          end
        end
      end
      ST_ISSUE_RD: begin
        if (accept) begin
          gen_adv = 1'b1;
          done_d  = done_inc;
          if (done_inc == count_q)             state_d = ST_DRAIN;
          else if (mode_q == WRITE_AND_CHECK)  state_d = ST_ISSUE_WR;
        end
      end
      ST_DRAIN: if (!trans_busy_i) state_d = ST_DONE;
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase

    // A compare error overrides any issue decision but still lets a same-cycle accept count.
    if ((state_q != ST_IDLE) && cmp_error_i) begin
      error_d = 1'b1;
      state_d = ST_DRAIN;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
      mode_q  <= WRITE_ONLY;
      count_q <= '0;
      done_q  <= '0;
      error_q <= 1'b0;
      tcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      count_q <= count_d;
      done_q  <= done_d;
      error_q <= error_d;
      tcnt_q  <= tcnt_d;
    end
  end

  assign test_error_o = error_q;
  assign trans_cnt_o  = tcnt_q;

endmodule

// File: doc/control_block.md
CONTROL_BLOCK -- requirements
Module: control_block

Interface
REQ-001 SHALL have parameters: none; all widths (ADDR_W, AMM_BURST_W, ADDR_TYPE) and CSR indices come from rtl_settings_pkg.
REQ-002 SHALL use one clock and an asynchronous, active-high reset.
REQ-003 Ports, clock and reset first:
- rst_i  in  1  asynchronous active-high reset
- clk_i  in  1  clock
- test_param_i  in  [CSR_SET_DATA:CSR_TEST_PARAM][31:0]  CSR test parameters
- start_i  in  1  one-cycle test start pulse
- trans_ready_i  in  1  transmitter can accept a transaction
- trans_busy_i  in  1  transmitter holds pending or in-flight work
- cmp_error_i  in  1  compare mismatch pulse
- trans_valid_o  out  1  transaction request
- trans_addr_o  out  ADDR_W  transaction address
- trans_type_o  out  1  0 = write, 1 = read
- test_busy_o  out  1  test running
- test_done_o  out  1  one-cycle completion pulse
- test_error_o  out  1  test aborted on compare error; held until next start
- trans_cnt_o  out  32  accepted transactions
REQ-004 Field map:
- CSR_TEST_PARAM[AMM_BURST_W-2:0]: burstcount
- CSR_TEST_PARAM[17:16]: test_mode
- CSR_TEST_PARAM[21:20]: addr_mode
- CSR_SET_ADDR[ADDR_W-1:0]: base/seed
- CSR_SET_DATA[31:16]: test_count (N addresses)

Function
REQ-005 SHALL implement FSM states IDLE, ISSUE_WR, ISSUE_RD, DRAIN, DONE.
REQ-006 IDLE + start_i: SHALL latch test_param_i, clear trans_cnt_o and test_error_o, load the address generator, then go to ISSUE_RD (READ_ONLY) or ISSUE_WR (otherwise); if test_count == 0, go to DRAIN.
REQ-007 start_i outside IDLE SHALL be ignored.
REQ-008 Handshake: trans_valid_o, trans_addr_o and trans_type_o SHALL be held stable until trans_valid_o && trans_ready_i (accept); a new request SHALL be asserted no earlier than the cycle after accept.
REQ-009 WRITE_ONLY: each accepted write advances the address; after N accepts, go to DRAIN.
REQ-010 READ_ONLY: same as WRITE_ONLY, with reads.
REQ-011 WRITE_AND_CHECK: an accepted write SHALL go to ISSUE_RD with the same address; an accepted read advances the address and returns to ISSUE_WR; after N write/read pairs, go to DRAIN.
REQ-012 Address modes:
- FIX (0): always base.
- INC (1): previous + burstcount + 1, wrapping modulo 2^ADDR_W.
- RND (2): 32-bit Galois LFSR (x^32+x^22+x^2+x+1) seeded with base (seed 0 replaced by 1); address = lfsr[ADDR_W-1:0]; advances only on address advance.
- Value 3 SHALL behave as FIX.
REQ-013 In BYTE ADDR_TYPE, INC step SHALL be (burstcount+1) << ADDR_B_W.
REQ-014 trans_cnt_o SHALL increment on every accept and saturate at 32'hFFFF_FFFF.
REQ-015 cmp_error_i in any non-IDLE state SHALL set test_error_o, deassert trans_valid_o next cycle (an accept in the same cycle still counts) and go to DRAIN.
REQ-016 cmp_error_i in IDLE SHALL be ignored.
REQ-017 DRAIN SHALL wait until trans_busy_i == 0, then go to DONE; DONE SHALL pulse test_done_o for one cycle and return to IDLE.
REQ-018 test_busy_o SHALL be 1 in every state except IDLE.

Reset
REQ-019 Reset SHALL force IDLE and drive trans_valid_o, trans_type_o, test_busy_o, test_done_o and test_error_o to 0, trans_addr_o to 0, trans_cnt_o to 0, and lfsr to 1; reset mid-test SHALL abort with no done pulse.

Structure
REQ-020 The shared package SHALL hold:
- addr_mode_t {FIX_ADDR, INC_ADDR, RND_ADDR}
- the existing test_mode_t
- CSR_SET_ADDR, placed between CSR_TEST_PARAM and CSR_SET_DATA
REQ-021 The address generator (FIX/INC/RND, load/advance) SHALL be a sub-module named addr_gen; the FSM and counters stay in control_block.

Verification
REQ-022 WRITE_ONLY, INC, base 0x100, burstcount 3, N=4, WORD mode, trans_ready_i always 1 -> writes at 0x100, 0x104, 0x108, 0x10C; trans_cnt_o = 4; test_done_o pulses once after trans_busy_i falls.
REQ-023 WRITE_AND_CHECK, FIX, base 0x40, N=2 -> trans_type_o sequence 0,1,0,1, all at address 0x40; trans_cnt_o = 4.
REQ-024 READ_ONLY, RND, seed 0, N=3 -> addresses equal the first three LFSR states after seed 1, matching the reference model.
REQ-025 trans_ready_i low for 5 cycles during a request -> trans_valid_o, trans_addr_o and trans_type_o stay stable; no count increment.
REQ-026 cmp_error_i pulse after the 2nd of N=10 accepts -> test_error_o = 1, no further requests, done pulse only after trans_busy_i = 0, trans_cnt_o = 2.
REQ-027 rst_i asserted mid-test, and start_i while busy -> all outputs reset immediately; a mid-test start_i has no effect.
